// File: rtl/score_accum.sv
// score_accum: multi-channel BCD score accumulator for the game core.
// Registered BCD adder tree feeding a saturating or wrapping running score.
module score_accum #(
  parameter int NUM         = 4,
  parameter int DIGITS      = 6,
  parameter int SATURATE    = 1,
  parameter int BONUS_DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    clear,
  input  logic [NUM-1:0]          add_valid,
  input  logic [NUM*DIGITS*4-1:0] add_val,
  output logic [DIGITS*4-1:0]     score,
  output logic [DIGITS*4-1:0]     hiscore,
  output logic                    overflow,
  output logic                    bonus,
  output logic                    bad_digit,
  output logic                    busy
);

  localparam int DW = DIGITS * 4;
  localparam int L  = (NUM > 1) ? $clog2(NUM) : 0;
  localparam int BL = BONUS_DIGIT * 4;
  localparam logic [DW-1:0] NINES = {DIGITS{4'h9}};

  function automatic logic [DW:0] bcd_add(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-1:0] s;
    logic [4:0]    d;
    logic          c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[i*4 +: 4] = d[3:0];
    end
    return {c, s};
  endfunction

  function automatic logic bcd_ok(input logic [DW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Level 0 is the input capture stage; levels 1..L are the tree.
  logic [DW-1:0] sum_q [L+1][NUM];
  logic [DW-1:0] sum_d [L+1][NUM];
  logic          tag_q [L+1][NUM];
  logic          tag_d [L+1][NUM];
  logic [L:0]    vld_q, vld_d;

  logic [DW-1:0] score_q, score_d;
  logic [DW-1:0] hiscore_q;
  logic          ovf_q, ovf_d;
  logic          bonus_q, bonus_d;
  logic          bad_q, bad_d;

  logic [DW:0]   pair_r;
  logic [DW:0]   acc_r;
  logic          acc_ov;

  always_comb begin
    pair_r = '0;
    vld_d  = '0;
    bad_d  = 1'b0;
    for (int k = 0; k <= L; k++) begin
      for (int j = 0; j < NUM; j++) begin
        sum_d[k][j] = '0;
        tag_d[k][j] = 1'b0;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (add_valid[i]) begin
        if (bcd_ok(add_val[i*DW +: DW])) begin
          sum_d[0][i] = add_val[i*DW +: DW];
          vld_d[0]    = 1'b1;
        end else begin
          bad_d = 1'b1;
        end
      end
    end
    for (int k = 1; k <= L; k++) begin
      vld_d[k] = vld_q[k-1];
      for (int j = 0; j < NUM; j++) begin
        if (2*j + 1 < NUM) begin
          pair_r = bcd_add(sum_q[k-1][2*j], sum_q[k-1][2*j+1]);
          sum_d[k][j] = pair_r[DW-1:0];
          tag_d[k][j] = pair_r[DW] | tag_q[k-1][2*j]
                      | tag_q[k-1][2*j+1];
        end else if (2*j < NUM) begin
          sum_d[k][j] = sum_q[k-1][2*j];
          tag_d[k][j] = tag_q[k-1][2*j];
        end
      end
    end
  end

  always_comb begin
    acc_r   = bcd_add(score_q, sum_q[L][0]);
    acc_ov  = vld_q[L] & (tag_q[L][0] | acc_r[DW]);
    score_d = score_q;
    if (vld_q[L]) begin
      if (acc_ov && SATURATE != 0) score_d = NINES;
      else                         score_d = acc_r[DW-1:0];
    end
    ovf_d   = ovf_q | acc_ov;
    // Upper-digit compare gives one pulse per update, none on wrap.
    bonus_d = score_d[DW-1:BL] > score_q[DW-1:BL];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k <= L; k++) begin
        for (int j = 0; j < NUM; j++) begin
          sum_q[k][j] <= '0;
          tag_q[k][j] <= 1'b0;
        end
      end
      vld_q     <= '0;
      score_q   <= '0;
      hiscore_q <= '0;
      ovf_q     <= 1'b0;
      bonus_q   <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      if (score_q > hiscore_q) hiscore_q <= score_q;
      if (clear) begin
        for (int k = 0; k <= L; k++) begin
          for (int j = 0; j < NUM; j++) begin
            sum_q[k][j] <= '0;
            tag_q[k][j] <= 1'b0;
          end
        end
        vld_q   <= '0;
        score_q <= '0;
        ovf_q   <= 1'b0;
        bonus_q <= 1'b0;
        bad_q   <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        tag_q   <= tag_d;
        vld_q   <= vld_d;
        score_q <= score_d;
        ovf_q   <= ovf_d;
        bonus_q <= bonus_d;
        bad_q   <= bad_d;
      end
    end
  end

  assign score     = score_q;
  assign hiscore   = hiscore_q;
  assign overflow  = ovf_q;
  assign bonus     = bonus_q;
  assign bad_digit = bad_q;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_score_accum.sv
// tb_score_accum: saturating and wrapping score_accum instances side by side,
// checked against an integer-arithmetic model of the score rules.
module tb_score_accum;

  localparam int NUM  = 4;
  localparam int DIG  = 6;
  localparam int DW   = DIG * 4;
  localparam int L    = 2;
  localparam int BD   = 4;
  localparam int MODV = 10 ** DIG;
  localparam int MAXV = MODV - 1;
  localparam int BDIV = 10 ** BD;

  logic clk = 1'b0;
  logic resetN, clear;
  logic [NUM-1:0]    add_valid;
  logic [NUM*DW-1:0] add_val;
  logic [DW-1:0] score_s, hi_s, score_w, hi_w;
  logic ovf_s, bon_s, bad_s, busy_s;
  logic ovf_w, bon_w, bad_w, busy_w;

  int n_chk  = 0;
  int n_fail = 0;

  int   m_score [2];
  int   m_hi    [2];
  logic m_ovf   [2];
  logic m_bon   [2];
  logic m_bad, m_busy;
  logic pipe_v [$];
  int   pipe_t [$];

  always #5 clk = ~clk;

  score_accum #(.NUM(NUM), .DIGITS(DIG), .SATURATE(1), .BONUS_DIGIT(BD))
  dut_s (
    .clk(clk), .resetN(resetN), .clear(clear),
    .add_valid(add_valid), .add_val(add_val),
    .score(score_s), .hiscore(hi_s), .overflow(ovf_s),
    .bonus(bon_s), .bad_digit(bad_s), .busy(busy_s)
  );

  score_accum #(.NUM(NUM), .DIGITS(DIG), .SATURATE(0), .BONUS_DIGIT(BD))
  dut_w (
    .clk(clk), .resetN(resetN), .clear(clear),
    .add_valid(add_valid), .add_val(add_val),
    .score(score_w), .hiscore(hi_w), .overflow(ovf_w),
    .bonus(bon_w), .bad_digit(bad_w), .busy(busy_w)
  );

  function automatic int from_bcd(input logic [DW-1:0] v);
    int r;
    r = 0;
    for (int i = DIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit is_bad(input logic [DW-1:0] v);
    bit b;
    b = 0;
    for (int i = 0; i < DIG; i++) if (v[i*4 +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_val(input bit bad);
    logic [DW-1:0] r;
    int nd, p;
    r  = '0;
    nd = ($urandom_range(0, 14) == 0) ? DIG : int'($urandom_range(1, 4));
    for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (bad) begin
      p = $urandom_range(0, DIG - 1);
      r[p*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  task automatic pipe_clear();
    pipe_v.delete();
    pipe_t.delete();
    for (int i = 0; i <= L; i++) begin
      pipe_v.push_back(1'b0);
      pipe_t.push_back(0);
    end
  endtask

  task automatic model_reset();
    pipe_clear();
    for (int s = 0; s < 2; s++) begin
      m_score[s] = 0;
      m_hi[s]    = 0;
      m_ovf[s]   = 1'b0;
      m_bon[s]   = 1'b0;
    end
    m_bad  = 1'b0;
    m_busy = 1'b0;
  endtask

  // Drive one cycle of inputs, step the model across the edge.
  task automatic tick(input logic clr, input logic [NUM-1:0] v,
                      input logic [NUM*DW-1:0] vals);
    int tot, n, ns, pt;
    logic acc, bd, pv;
    clear = clr;
    add_valid = v;
    add_val = vals;
    @(posedge clk);
    #1;
    tot = 0;
    acc = 1'b0;
    bd  = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (v[i]) begin
        if (is_bad(vals[i*DW +: DW])) bd = 1'b1;
        else begin
          acc = 1'b1;
          tot += from_bcd(vals[i*DW +: DW]);
        end
      end
    end
    for (int s = 0; s < 2; s++) if (m_score[s] > m_hi[s]) m_hi[s] = m_score[s];
    if (clr) begin
      pipe_clear();
      for (int s = 0; s < 2; s++) begin
        m_score[s] = 0;
        m_ovf[s]   = 1'b0;
        m_bon[s]   = 1'b0;
      end
      m_bad = 1'b0;
    end else begin
      pv = pipe_v.pop_front();
      pt = pipe_t.pop_front();
      pipe_v.push_back(acc);
      pipe_t.push_back(tot);
      for (int s = 0; s < 2; s++) begin
        m_bon[s] = 1'b0;
        if (pv) begin
          n  = m_score[s] + pt;
          ns = n;
          if (n > MAXV) begin
            m_ovf[s] = 1'b1;
            ns = (s == 0) ? MAXV : n % MODV;
          end
          m_bon[s] = (ns / BDIV) > (m_score[s] / BDIV);
          m_score[s] = ns;
        end
      end
      m_bad = bd;
    end
    m_busy = 1'b0;
    foreach (pipe_v[i]) m_busy |= pipe_v[i];
    clear = 1'b0;
    add_valid = '0;
    add_val = '0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #7;
    n_chk += 4;
    if (score_s !== '0 || score_w !== '0) begin
      n_fail++;
      $display("FAIL reset score: got %h/%h want 0", score_s, score_w);
    end
    if (hi_s !== '0 || hi_w !== '0) begin
      n_fail++;
      $display("FAIL reset hiscore: got %h/%h want 0", hi_s, hi_w);
    end
    if ({ovf_s, bon_s, bad_s, busy_s} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b want 0000",
               {ovf_s, bon_s, bad_s, busy_s});
    end
    if ({ovf_w, bon_w, bad_w, busy_w} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset flags_w: got %b want 0000",
               {ovf_w, bon_w, bad_w, busy_w});
    end
    resetN = 1'b1;
  endtask

  task automatic test_tree_latency();
    logic [NUM*DW-1:0] v;
    logic [DW-1:0] exp_s [4];
    logic exp_b [4];
    exp_s = '{24'h0, 24'h0, 24'h0, 24'h000140};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b0};
    tick(1'b1, '0, '0);
    v = {24'h000005, 24'h000100, 24'h000025, 24'h000010};
    tick(1'b0, 4'b1111, v);
    for (int e = 0; e < 4; e++) begin
      if (e > 0) tick(1'b0, '0, '0);
      n_chk += 3;
      if (score_s !== exp_s[e]) begin
        n_fail++;
        $display("FAIL latency score e%0d: got %h want %h", e + 1,
                 score_s, exp_s[e]);
      end
      if (busy_s !== exp_b[e]) begin
        n_fail++;
        $display("FAIL latency busy e%0d: got %b want %b", e + 1,
                 busy_s, exp_b[e]);
      end
      if (bon_s !== 1'b0) begin
        n_fail++;
        $display("FAIL latency bonus e%0d: got %b want 0", e + 1, bon_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_s [8];
    logic exp_b [8];
    exp_s = '{24'h0, 24'h0, 24'h0, 24'h50, 24'h100, 24'h150, 24'h150, 24'h150};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tick(1'b1, '0, '0);
    for (int e = 0; e < 8; e++) begin
      if (e < 3) tick(1'b0, 4'b0001, {72'h0, 24'h000050});
      else       tick(1'b0, '0, '0);
      n_chk += 2;
      if (score_s !== exp_s[e]) begin
        n_fail++;
        $display("FAIL b2b score e%0d: got %h want %h", e + 1,
                 score_s, exp_s[e]);
      end
      if (busy_s !== exp_b[e]) begin
        n_fail++;
        $display("FAIL b2b busy e%0d: got %b want %b", e + 1,
                 busy_s, exp_b[e]);
      end
    end
  endtask

  task automatic test_bonus();
    tick(1'b1, '0, '0);
    tick(1'b0, 4'b0001, {72'h0, 24'h009990});
    repeat (3) tick(1'b0, '0, '0);
    tick(1'b0, 4'b0001, {72'h0, 24'h000020});
    repeat (2) tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    n_chk += 3;
    if (score_s !== 24'h010010) begin
      n_fail++;
      $display("FAIL bonus score: got %h want 010010", score_s);
    end
    if (bon_s !== 1'b1) begin
      n_fail++;
      $display("FAIL bonus pulse: got %b want 1", bon_s);
    end
    if (hi_s !== 24'h009990) begin
      n_fail++;
      $display("FAIL bonus hiscore lag: got %h want 009990", hi_s);
    end
    tick(1'b0, '0, '0);
    n_chk += 2;
    if (bon_s !== 1'b0) begin
      n_fail++;
      $display("FAIL bonus width: got %b want 0", bon_s);
    end
    if (hi_s !== 24'h010010) begin
      n_fail++;
      $display("FAIL bonus hiscore: got %h want 010010", hi_s);
    end
  endtask

  task automatic test_overflow();
    tick(1'b1, '0, '0);
    tick(1'b0, 4'b0010, {48'h0, 24'h999950, 24'h0});
    repeat (3) tick(1'b0, '0, '0);
    tick(1'b0, 4'b0001, {72'h0, 24'h000100});
    repeat (3) tick(1'b0, '0, '0);
    n_chk += 6;
    if (score_s !== 24'h999999 || ovf_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat ovf: got %h/%b want 999999/1", score_s, ovf_s);
    end
    if (score_w !== 24'h000050 || ovf_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap ovf: got %h/%b want 000050/1", score_w, ovf_w);
    end
    if (bon_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sat bonus: got %b want 0", bon_s);
    end
    if (bon_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap bonus: got %b want 0", bon_w);
    end
    tick(1'b0, 4'b1000, {24'h000001, 72'h0});
    repeat (3) tick(1'b0, '0, '0);
    if (score_s !== 24'h999999 || ovf_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat stick: got %h/%b want 999999/1", score_s, ovf_s);
    end
    if (score_w !== 24'h000051) begin
      n_fail++;
      $display("FAIL wrap add: got %h want 000051", score_w);
    end
    tick(1'b1, '0, '0);
    n_chk += 3;
    if (score_s !== '0 || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
      n_fail++;
      $display("FAIL clear ovf: got %h/%b/%b want 0/0/0",
               score_s, ovf_s, ovf_w);
    end
    if (hi_s !== 24'h999999) begin
      n_fail++;
      $display("FAIL clear hiscore: got %h want 999999", hi_s);
    end
    if (hi_w !== 24'h999950) begin
      n_fail++;
      $display("FAIL clear hiscore_w: got %h want 999950", hi_w);
    end
  endtask

  task automatic test_bad_clear();
    tick(1'b1, '0, '0);
    tick(1'b0, 4'b1111, {24'h000001, 24'h0000A0, 24'h000001, 24'h000001});
    n_chk++;
    if (bad_s !== 1'b1) begin
      n_fail++;
      $display("FAIL bad pulse: got %b want 1", bad_s);
    end
    tick(1'b0, '0, '0);
    n_chk++;
    if (bad_s !== 1'b0) begin
      n_fail++;
      $display("FAIL bad width: got %b want 0", bad_s);
    end
    repeat (2) tick(1'b0, '0, '0);
    n_chk++;
    if (score_s !== 24'h000003) begin
      n_fail++;
      $display("FAIL bad score: got %h want 000003", score_s);
    end
    tick(1'b0, 4'b0001, {72'h0, 24'h000500});
    tick(1'b0, 4'b0001, {72'h0, 24'h000500});
    tick(1'b1, 4'b0001, {72'h0, 24'h000700});
    n_chk++;
    if (score_s !== '0 || ovf_s !== 1'b0 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL flight clear: got %h/%b/%b want 0/0/0",
               score_s, ovf_s, busy_s);
    end
    for (int e = 0; e < 5; e++) begin
      tick(1'b0, '0, '0);
      n_chk++;
      if (score_s !== '0 || hi_s !== 24'h999999) begin
        n_fail++;
        $display("FAIL flight discard e%0d: got %h/%h want 000000/999999",
                 e, score_s, hi_s);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 4'b1111, {24'h000300, 24'h000200, 24'h000100, 24'h000050});
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (score_s !== '0 || hi_s !== '0 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got %h/%h/%b want 0/0/0", score_s, hi_s, busy_s);
    end
    #2;
    resetN = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick(1'b0, '0, '0);
      n_chk++;
      if (score_s !== '0 || busy_s !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset drain e%0d: got %h/%b want 0/0",
                 e, score_s, busy_s);
      end
    end
  endtask

  task automatic test_random();
    logic [NUM-1:0] v;
    logic [NUM*DW-1:0] vals;
    logic clr;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM; i++) begin
        v[i] = ($urandom_range(0, 2) != 0);
        vals[i*DW +: DW] = rand_val($urandom_range(0, 11) == 0);
      end
      tick(clr, v, vals);
      n_chk += 8;
      if (score_s !== to_bcd(m_score[0])) begin
        n_fail++;
        $display("FAIL rnd score c%0d: got %h want %h", c, score_s,
                 to_bcd(m_score[0]));
      end
      if (score_w !== to_bcd(m_score[1])) begin
        n_fail++;
        $display("FAIL rnd score_w c%0d: got %h want %h", c, score_w,
                 to_bcd(m_score[1]));
      end
      if (hi_s !== to_bcd(m_hi[0]) || hi_w !== to_bcd(m_hi[1])) begin
        n_fail++;
        $display("FAIL rnd hiscore c%0d: got %h/%h want %h/%h", c, hi_s,
                 hi_w, to_bcd(m_hi[0]), to_bcd(m_hi[1]));
      end
      if (ovf_s !== m_ovf[0] || ovf_w !== m_ovf[1]) begin
        n_fail++;
        $display("FAIL rnd overflow c%0d: got %b%b want %b%b", c, ovf_s,
                 ovf_w, m_ovf[0], m_ovf[1]);
      end
      if (bon_s !== m_bon[0]) begin
        n_fail++;
        $display("FAIL rnd bonus c%0d: got %b want %b", c, bon_s, m_bon[0]);
      end
      if (bon_w !== m_bon[1]) begin
        n_fail++;
        $display("FAIL rnd bonus_w c%0d: got %b want %b", c, bon_w, m_bon[1]);
      end
      if (bad_s !== m_bad || bad_w !== m_bad) begin
        n_fail++;
        $display("FAIL rnd bad_digit c%0d: got %b%b want %b", c, bad_s,
                 bad_w, m_bad);
      end
      if (busy_s !== m_busy || busy_w !== m_busy) begin
        n_fail++;
        $display("FAIL rnd busy c%0d: got %b%b want %b", c, busy_s,
                 busy_w, m_busy);
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    clear = 1'b0;
    add_valid = '0;
    add_val = '0;
    model_reset();
    test_reset();
    test_tree_latency();
    test_back_to_back();
    test_bonus();
    test_overflow();
    test_bad_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
